// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out shift serializer.
// Holds the FSM state encoding and the counter sizing helper.
package shift_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ser_state_t;

    // Smallest r with 2**r >= v; for v == 2 this gives 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-WIDTH bit index counter with clear, enable and terminal-count flag.
module shift_bit_counter
    import shift_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      en,
    output logic [clog2(WIDTH)-1:0]   count,
    output logic                      last
);

    localparam int unsigned CW = clog2(WIDTH);

    assign last = (count == CW'(WIDTH - 1));

    // Wrap at the terminal count so values >= WIDTH never appear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out shift register with valid/ready load, shift-enable
// stepping and a one-cycle done pulse after the last bit.
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic                      _clock,
    input  logic                      _reset,
    input  logic                      _load_valid,
    input  logic [WIDTH-1:0]          _D,
    output logic                      _load_ready,
    input  logic                      _shift_en,
    output logic                      _serial,
    output logic                      _busy,
    output logic                      _done,
    output logic [clog2(WIDTH)-1:0]   _count,
    output logic                      _return
);

    ser_state_t       state;
    logic [WIDTH-1:0] sr;
    logic             load_ok;
    logic             shift_ok;
    logic             last_bit;

    assign _load_ready = (state != ST_SHIFT);
    assign load_ok     = _load_valid && _load_ready;
    assign shift_ok    = (state == ST_SHIFT) && _shift_en;

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (_clock),
        .rst   (_reset),
        .clear (load_ok),
        .en    (shift_ok),
        .count (_count),
        .last  (last_bit)
    );

    // State and shift register; the outgoing bit always sits at one end of sr.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state <= ST_IDLE;
            sr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_ok) begin
                        sr    <= _D;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (_shift_en) begin
                        sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
                        if (last_bit) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (load_ok) begin
                        sr    <= _D;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign _busy   = (state == ST_SHIFT);
    assign _done   = (state == ST_DONE);
    assign _serial = (state == ST_SHIFT) ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_LEVEL;
    assign _return = _serial;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer: LSB-first and MSB-first instances
// share stimulus and are checked against hand-computed bit sequences.
module tb_shift_serializer;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] d;
    logic       shift;

    logic       ready_l, ser_l, busy_l, done_l, ret_l;
    logic [2:0] cnt_l;
    logic       ready_m, ser_m, busy_m, done_m, ret_m;
    logic [2:0] cnt_m;

    int errors = 0;
    int checks = 0;

    shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        ._clock(clk), ._reset(rst), ._load_valid(valid), ._D(d), ._load_ready(ready_l),
        ._shift_en(shift), ._serial(ser_l), ._busy(busy_l), ._done(done_l),
        ._count(cnt_l), ._return(ret_l)
    );

    shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        ._clock(clk), ._reset(rst), ._load_valid(valid), ._D(d), ._load_ready(ready_m),
        ._shift_en(shift), ._serial(ser_m), ._busy(busy_m), ._done(done_m),
        ._count(cnt_m), ._return(ret_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Status outputs of both instances against one expected set.
    task automatic check_status(input string tag, input logic busy, input logic done,
                                input logic ready, input logic [2:0] cnt);
        check({tag, ".busy_l"},  32'(busy_l),  32'(busy));
        check({tag, ".busy_m"},  32'(busy_m),  32'(busy));
        check({tag, ".done_l"},  32'(done_l),  32'(done));
        check({tag, ".done_m"},  32'(done_m),  32'(done));
        check({tag, ".ready_l"}, 32'(ready_l), 32'(ready));
        check({tag, ".ready_m"}, 32'(ready_m), 32'(ready));
        check({tag, ".cnt_l"},   32'(cnt_l),   32'(cnt));
        check({tag, ".cnt_m"},   32'(cnt_m),   32'(cnt));
    endtask

    task automatic check_ser(input string tag, input logic exp_l, input logic exp_m);
        check({tag, ".ser_l"}, 32'(ser_l), 32'(exp_l));
        check({tag, ".ret_l"}, 32'(ret_l), 32'(exp_l));
        check({tag, ".ser_m"}, 32'(ser_m), 32'(exp_m));
        check({tag, ".ret_m"}, 32'(ret_m), 32'(exp_m));
    endtask

    // Eight shifting cycles; seq bit i is the i-th bit sent.
    task automatic run_word(input string tag, input logic [7:0] seq_l, input logic [7:0] seq_m);
        for (int i = 0; i < 8; i++) begin
            check_ser($sformatf("%s.b%0d", tag, i), seq_l[i], seq_m[i]);
            check_status($sformatf("%s.s%0d", tag, i), 1'b1, 1'b0, 1'b0, 3'(i));
            tick();
        end
    endtask

    initial begin
        logic [7:0] sl;
        logic [7:0] sm;

        rst = 1'b1; valid = 1'b0; d = 8'h00; shift = 1'b0;
        tick();
        tick();
        check_ser("reset", 1'b0, 1'b0);
        check_status("reset", 1'b0, 1'b0, 1'b1, 3'd0);
        rst = 1'b0;

        // Shift strobes in IDLE have no effect.
        shift = 1'b1;
        tick();
        tick();
        shift = 1'b0;
        tick();
        check_ser("idle_shift", 1'b0, 1'b0);
        check_status("idle_shift", 1'b0, 1'b0, 1'b1, 3'd0);

        // A5 with shift held high: palindromic, same order for both instances.
        valid = 1'b1; d = 8'hA5; shift = 1'b1;
        tick();
        valid = 1'b0;
        run_word("a5", 8'hA5, 8'hA5);
        check_ser("a5_done", 1'b0, 1'b0);
        check_status("a5_done", 1'b0, 1'b1, 1'b1, 3'd0);
        shift = 1'b0;
        tick();
        check_status("a5_idle", 1'b0, 1'b0, 1'b1, 3'd0);

        // 0F with shift on alternate cycles, FF offered mid-word.
        valid = 1'b1; d = 8'h0F;
        tick();
        valid = 1'b0;
        sl = 8'h0F;
        sm = 8'hF0;
        for (int i = 0; i < 8; i++) begin
            shift = 1'b0;
            check_ser($sformatf("stall.a%0d", i), sl[i], sm[i]);
            check_status($sformatf("stall.a%0d", i), 1'b1, 1'b0, 1'b0, 3'(i));
            if (i == 3) begin
                valid = 1'b1;
                d = 8'hFF;
            end
            tick();
            check_ser($sformatf("stall.h%0d", i), sl[i], sm[i]);
            check_status($sformatf("stall.h%0d", i), 1'b1, 1'b0, 1'b0, 3'(i));
            valid = 1'b0;
            shift = 1'b1;
            tick();
        end
        shift = 1'b0;
        check_ser("stall_done", 1'b0, 1'b0);
        check_status("stall_done", 1'b0, 1'b1, 1'b1, 3'd0);
        tick();
        check_status("stall_idle", 1'b0, 1'b0, 1'b1, 3'd0);

        // Back-to-back: 01 then 80 with valid held high.
        valid = 1'b1; d = 8'h01; shift = 1'b1;
        tick();
        d = 8'h80;
        run_word("b2b1", 8'h01, 8'h80);
        check_ser("b2b_gap", 1'b0, 1'b0);
        check_status("b2b_gap", 1'b0, 1'b1, 1'b1, 3'd0);
        tick();
        valid = 1'b0;
        run_word("b2b2", 8'h80, 8'h01);
        check_status("b2b_done", 1'b0, 1'b1, 1'b1, 3'd0);
        shift = 1'b0;
        tick();

        // Reset after three bits of FF discards the word.
        valid = 1'b1; d = 8'hFF; shift = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        tick();
        check_ser("mid", 1'b1, 1'b1);
        check_status("mid", 1'b1, 1'b0, 1'b0, 3'd3);
        rst = 1'b1;
        tick();
        check_ser("mid_rst", 1'b0, 1'b0);
        check_status("mid_rst", 1'b0, 1'b0, 1'b1, 3'd0);
        rst = 1'b0; shift = 1'b0;
        tick();
        check_status("post_rst", 1'b0, 1'b0, 1'b1, 3'd0);

        valid = 1'b1; d = 8'h02; shift = 1'b1;
        tick();
        valid = 1'b0;
        run_word("w02", 8'h02, 8'h40);
        check_status("w02_done", 1'b0, 1'b1, 1'b1, 3'd0);
        shift = 1'b0;
        tick();
        check_status("w02_idle", 1'b0, 1'b0, 1'b1, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
